// File: rtl/indication_word_serializer_if.sv
// indication_word_serializer_if: message enqueue and word-output signals of the serializer.
interface indication_word_serializer_if;
  logic        pipe_enq_ena;
  logic [95:0] pipe_enq_v;
  logic        pipe_enq_rdy;
  logic        out_word_ena;
  logic [31:0] out_word_data;
  logic        out_word_last;
  logic        out_word_rdy;
  logic [31:0] msg_count;
  modport slave (
    input  pipe_enq_ena, pipe_enq_v, out_word_rdy,
    output pipe_enq_rdy, out_word_ena, out_word_data, out_word_last, msg_count
  );
  modport master (
    output pipe_enq_ena, pipe_enq_v, out_word_rdy,
    input  pipe_enq_rdy, out_word_ena, out_word_data, out_word_last, msg_count
  );
endinterface

// File: rtl/indication_word_serializer.sv
// indication_word_serializer: buffers 96-bit messages in a 2-entry FIFO and emits each as tag, method, value words.
module indication_word_serializer (
  input logic                         CLK,
  input logic                         nRST,
  indication_word_serializer_if.slave bus
);
  typedef enum logic [1:0] {TAG = 2'd0, METH = 2'd1, VAL = 2'd2} phase_e;
  logic [95:0] mem_q [2];
  logic        head_q, head_d, tail_q, tail_d;
  logic [1:0]  cnt_q, cnt_d;
  phase_e      phase_q, phase_d;
  logic [31:0] msg_count_q, msg_count_d;
  logic        enq, deq, pop;
  logic [95:0] head_word;
  assign bus.pipe_enq_rdy = cnt_q != 2'd2;
  assign bus.out_word_ena = cnt_q != 2'd0;
  assign bus.msg_count    = msg_count_q;
  always_comb begin
    head_word = mem_q[head_q];
    enq = bus.pipe_enq_ena & bus.pipe_enq_rdy;
    deq = bus.out_word_ena & bus.out_word_rdy;
    pop = deq & (phase_q == VAL);
    bus.out_word_data = !bus.out_word_ena ? 32'd0 :
                        phase_q == TAG    ? head_word[31:0] :
                        phase_q == METH   ? head_word[63:32] : head_word[95:64];
    bus.out_word_last = bus.out_word_ena & (phase_q == VAL);
    head_d = head_q ^ pop;
    tail_d = tail_q ^ enq;
    cnt_d = cnt_q + {1'b0, enq} - {1'b0, pop};
    phase_d = pop ? TAG : deq ? (phase_q == TAG ? METH : VAL) : phase_q;
    msg_count_d = msg_count_q + {31'd0, pop};
  end
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      mem_q[0]    <= '0;
      mem_q[1]    <= '0;
      head_q      <= 1'b0;
      tail_q      <= 1'b0;
      cnt_q       <= 2'd0;
      phase_q     <= TAG;
      msg_count_q <= '0;
    end else begin
      if (enq) mem_q[tail_q] <= bus.pipe_enq_v;
      head_q      <= head_d;
      tail_q      <= tail_d;
      cnt_q       <= cnt_d;
      phase_q     <= phase_d;
      msg_count_q <= msg_count_d;
    end
  end
endmodule

// File: tb/tb_indication_word_serializer.sv
// tb_indication_word_serializer: scoreboard bench; expected words queued at enqueue, checked by a negedge monitor.
module tb_indication_word_serializer;
  logic CLK = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;
  indication_word_serializer_if bus ();
  indication_word_serializer dut (.CLK(CLK), .nRST(nRST), .bus(bus));
  typedef struct packed {logic [31:0] data; logic last;} word_t;
  word_t       exp_q[$];
  logic [31:0] exp_cnt = '0;
  int          compared = 0;
  int          mismatched = 0;
  int          rdy_mode = 1;
  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask
  always @(negedge CLK) begin
    int occ;
    if (nRST) begin
      occ = (exp_q.size() + 2) / 3;
      check("enq_rdy", 32'(bus.pipe_enq_rdy), 32'(occ != 2));
      check("out_ena", 32'(bus.out_word_ena), 32'(exp_q.size() != 0));
      check("msg_count", bus.msg_count, exp_cnt);
      if (!bus.out_word_ena) begin
        check("idle_data", bus.out_word_data, 32'd0);
        check("idle_last", 32'(bus.out_word_last), 32'd0);
      end else if (exp_q.size() != 0) begin
        check("data", bus.out_word_data, exp_q[0].data);
        check("last", 32'(bus.out_word_last), 32'(exp_q[0].last));
        if (bus.out_word_rdy) begin
          if (exp_q[0].last) exp_cnt++;
          void'(exp_q.pop_front());
        end
      end
    end
  end
  always @(posedge CLK) begin
    #1;
    bus.out_word_rdy = rdy_mode == 0 ? 1'b0 : rdy_mode == 1 ? 1'b1 :
                       rdy_mode == 2 ? ~bus.out_word_rdy : 1'($urandom);
  end
  task automatic set_rdy(int m);
    rdy_mode = m;
    if (m < 2) bus.out_word_rdy = 1'(m);
  endtask
  task automatic idle(int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask
  task automatic send(logic [95:0] v);
    int waited = 0;
    while (!bus.pipe_enq_rdy && waited < 100) begin
      @(posedge CLK);
      #1;
      waited++;
    end
    if (!bus.pipe_enq_rdy) begin
      compared++;
      mismatched++;
      $display("FAIL enq_timeout: pipe_rdy got 0 expected 1 after %0d cycles", waited);
      return;
    end
    bus.pipe_enq_ena = 1'b1;
    bus.pipe_enq_v = v;
    @(posedge CLK);
    if (nRST) begin
      exp_q.push_back('{v[31:0], 1'b0});
      exp_q.push_back('{v[63:32], 1'b0});
      exp_q.push_back('{v[95:64], 1'b1});
    end
    #1 bus.pipe_enq_ena = 1'b0;
  endtask
  task automatic do_reset();
    nRST = 1'b0;
    @(posedge CLK);
    exp_q.delete();
    exp_cnt = '0;
    #1 nRST = 1'b1;
  endtask
  initial begin
    int n;
    bus.pipe_enq_ena = 1'b0;
    bus.pipe_enq_v = '0;
    bus.out_word_rdy = 1'b1;
    repeat (2) @(posedge CLK);
    #1 nRST = 1'b1;
    idle(2);
    send({32'h0000000A, 32'h00000005, 32'h00000001});
    idle(5);
    send({32'h33, 32'h22, 32'h11});
    send({32'h66, 32'h55, 32'h44});
    idle(8);
    set_rdy(0);
    fork
      begin
        send({32'hA3, 32'hA2, 32'hA1});
        send({32'hB3, 32'hB2, 32'hB1});
        send({32'hC3, 32'hC2, 32'hC1});
      end
      begin
        idle(10);
        set_rdy(1);
      end
    join
    idle(12);
    set_rdy(2);
    send({32'hD3, 32'hD2, 32'hD1});
    idle(10);
    set_rdy(1);
    send({32'hE3, 32'hE2, 32'hE1});
    idle(2);
    send({32'hF3, 32'hF2, 32'hF1});
    idle(6);
    send({32'h1003, 32'h1002, 32'h1001});
    send({32'h2003, 32'h2002, 32'h2001});
    do_reset();
    idle(6);
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 7) == 0) set_rdy(int'($urandom_range(1, 3)));
      if ($urandom_range(0, 49) == 0) do_reset();
      send({$urandom, $urandom, $urandom});
      n = int'($urandom_range(0, 3));
      if (n > 0) idle(n);
    end
    set_rdy(1);
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge CLK);
      n++;
    end
    if (exp_q.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain: words left %0d expected 0", exp_q.size());
    end
    idle(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
